// File: rtl/lc3_io_ctrl.sv
// lc3_io_ctrl: LC-3 memory-mapped keyboard/display controller (KBSR/KBDR/DSR/DDR at xFE00-xFE06).
// Optional feature: define LC3_IO_DISP_DELAY_EN to insert a DISP_DELAY-cycle HOLD after each display handshake.
module lc3_io_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DISP_DELAY = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] din,
    input  logic        we,
    input  logic        re,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        kb_irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = $clog2(DISP_DELAY + 1);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_SEND = 2'd1,
        D_HOLD = 2'd2
    } disp_state_t;

    disp_state_t   dstate;
    logic [DW-1:0] dly_cnt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          ie;

    logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_any;
    logic rd_acc, nonempty, push, pop, disp_idle, ddr_acc;
    logic [15:0] rd_data;
    logic unused_din;

    // Only IE and the display byte are ever taken from the write data.
    assign unused_din = ^{din[15], din[13:8]};

    assign sel_kbsr  = (addr == 16'hFE00);
    assign sel_kbdr  = (addr == 16'hFE02);
    assign sel_dsr   = (addr == 16'hFE04);
    assign sel_ddr   = (addr == 16'hFE06);
    assign sel_any   = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

    // A write in the same cycle suppresses the read entirely.
    assign rd_acc    = re && !we && sel_any;
    assign nonempty  = (count != '0);
    assign pop       = rd_acc && sel_kbdr && nonempty;
    assign push      = kb_valid && kb_ready;
    assign disp_idle = (dstate == D_IDLE);
    assign ddr_acc   = we && sel_ddr && disp_idle;

    assign kb_irq    = ie && nonempty;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Read mux reflects state before this edge's push/pop.
    always_comb begin
        rd_data = 16'h0000;
        if (sel_kbsr) begin
            rd_data = {nonempty, ie, 14'h0000};
        end else if (sel_kbdr) begin
            rd_data = {8'h00, (nonempty ? mem[rd_ptr] : 8'h00)};
        end else if (sel_dsr) begin
            rd_data = {disp_idle, 15'h0000};
        end else if (sel_ddr) begin
            rd_data = {8'h00, disp_data};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= kb_data;
        end
    end

    // Keyboard FIFO bookkeeping, IE and bus read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            kb_ready   <= 1'b1;
            ie         <= 1'b0;
            dout       <= 16'h0000;
            dout_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count_nxt;
            kb_ready <= (count_nxt != CW'(FIFO_DEPTH));
            if (we && sel_kbsr) begin
                ie <= din[14];
            end
            dout_valid <= rd_acc;
            if (rd_acc) begin
                dout <= rd_data;
            end
        end
    end

    // Display output state machine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dstate     <= D_IDLE;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
            dly_cnt    <= '0;
        end else begin
            case (dstate)
                D_IDLE: begin
                    if (ddr_acc) begin
                        disp_data  <= din[7:0];
                        disp_valid <= 1'b1;
                        dstate     <= D_SEND;
                    end
                end
                D_SEND: begin
                    if (disp_ready) begin
                        disp_valid <= 1'b0;
`ifdef LC3_IO_DISP_DELAY_EN
                        dstate     <= D_HOLD;
                        dly_cnt    <= DW'(DISP_DELAY);
`else
                        dstate     <= D_IDLE;
`endif
                    end
                end
                D_HOLD: begin
                    if (dly_cnt <= DW'(1)) begin
                        dly_cnt <= '0;
                        dstate  <= D_IDLE;
                    end else begin
                        dly_cnt <= dly_cnt - DW'(1);
                    end
                end
                default: begin
                    dstate <= D_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_io_ctrl.sv
// tb_lc3_io_ctrl: directed bench for lc3_io_ctrl; read responses are checked by a queue-based scoreboard.
module tb_lc3_io_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] din = 16'h0000;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 1'b0;
    logic        kb_irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];

    lc3_io_ctrl #(.FIFO_DEPTH(4), .DISP_DELAY(8)) dut (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .re(re),
        .dout(dout), .dout_valid(dout_valid),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
        .kb_irq(kb_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.val = exp;
        exp_q.push_back(e);
        addr = a;
        re   = 1'b1;
        @(posedge clk); #1;
        re   = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk); #1;
        we   = 1'b0;
    endtask

    task automatic kb_push(input logic [7:0] d);
        kb_valid = 1'b1;
        kb_data  = d;
        @(posedge clk); #1;
        kb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every dout_valid pulse consumes one expected read response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dout_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_dout_valid: got dout=%h with no read pending", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e.val) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", e.tag, dout, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", dout, 16'h0000);
        check("rst_dout_valid", 16'(dout_valid), 16'h0000);
        check("rst_kb_ready", 16'(kb_ready), 16'h0001);
        check("rst_disp_valid", 16'(disp_valid), 16'h0000);
        check("rst_disp_data", 16'(disp_data), 16'h0000);
        check("rst_kb_irq", 16'(kb_irq), 16'h0000);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_read("dsr_after_reset", 16'hFE04, 16'h8000);
        bus_read("kbsr_after_reset", 16'hFE00, 16'h0000);

        // Basic keyboard path
        kb_push(8'h41);
        kb_push(8'h42);
        bus_read("kbsr_two", 16'hFE00, 16'h8000);
        bus_read("kbdr_A", 16'hFE02, 16'h0041);
        bus_read("kbdr_B", 16'hFE02, 16'h0042);
        bus_read("kbdr_empty", 16'hFE02, 16'h0000);
        bus_read("kbsr_empty", 16'hFE00, 16'h0000);

        // Fill past capacity
        for (int i = 0; i < 5; i++) begin
            kb_push(8'h10 + 8'(i));
            if (i == 3) check("kb_ready_full", 16'(kb_ready), 16'h0000);
        end
        check("kb_ready_still_full", 16'(kb_ready), 16'h0000);
        for (int i = 0; i < 4; i++) begin
            bus_read("kbdr_fill_order", 16'hFE02, 16'h0010 + 16'(i));
        end
        bus_read("kbdr_fifth_dropped", 16'hFE02, 16'h0000);
        check("kb_ready_after_drain", 16'(kb_ready), 16'h0001);

        // Pointer wrap run
        for (int i = 0; i < 6; i++) begin
            kb_push(8'h20 + 8'(i));
            bus_read("kbdr_wrap", 16'hFE02, 16'h0020 + 16'(i));
        end

        // Interrupt enable
        bus_write(16'hFE00, 16'h4000);
        check("irq_empty", 16'(kb_irq), 16'h0000);
        kb_push(8'h0D);
        check("irq_set", 16'(kb_irq), 16'h0001);
        bus_read("kbsr_ie_ne", 16'hFE00, 16'hC000);
        bus_read("kbdr_cr", 16'hFE02, 16'h000D);
        check("irq_clear", 16'(kb_irq), 16'h0000);
        bus_write(16'hFE00, 16'hBFFF);
        bus_read("kbsr_ie_off", 16'hFE00, 16'h0000);

        // Display handshake with stalled sink
        disp_ready = 1'b0;
        bus_write(16'hFE06, 16'h0048);
        check("disp_valid_rise", 16'(disp_valid), 16'h0001);
        check("disp_data_H", 16'(disp_data), 16'h0048);
        bus_read("dsr_busy", 16'hFE04, 16'h0000);
        bus_write(16'hFE06, 16'h0049);
        idle(2);
        check("disp_data_stable", 16'(disp_data), 16'h0048);
        check("disp_valid_stable", 16'(disp_valid), 16'h0001);
        bus_read("ddr_read", 16'hFE06, 16'h0048);
        disp_ready = 1'b1;
        @(posedge clk); #1;
        disp_ready = 1'b0;
        check("disp_valid_fall", 16'(disp_valid), 16'h0000);
`ifdef LC3_IO_DISP_DELAY_EN
        bus_read("dsr_hold", 16'hFE04, 16'h0000);
        idle(7);
        bus_read("dsr_after_hold", 16'hFE04, 16'h8000);
`else
        bus_read("dsr_ready_again", 16'hFE04, 16'h8000);
`endif

        // Simultaneous push and pop at count 2
        kb_push(8'h31);
        kb_push(8'h32);
        kb_valid = 1'b1;
        kb_data  = 8'h33;
        bus_read("kbdr_push_pop", 16'hFE02, 16'h0031);
        kb_valid = 1'b0;
        bus_read("kbsr_push_pop", 16'hFE00, 16'h8000);
        bus_read("kbdr_pp_2", 16'hFE02, 16'h0032);
        bus_read("kbdr_pp_3", 16'hFE02, 16'h0033);
        bus_read("kbdr_pp_empty", 16'hFE02, 16'h0000);

        // we & re together: no pop, no read response; then ignored address
        kb_push(8'h44);
        addr = 16'hFE02;
        din  = 16'h0000;
        we   = 1'b1;
        re   = 1'b1;
        @(posedge clk); #1;
        we   = 1'b0;
        re   = 1'b0;
        @(negedge clk);
        check("we_re_no_valid", 16'(dout_valid), 16'h0000);
        bus_read("kbdr_after_we_re", 16'hFE02, 16'h0044);
        addr = 16'hFE08;
        re   = 1'b1;
        @(posedge clk); #1;
        re   = 1'b0;
        @(negedge clk);
        check("bad_addr_no_valid", 16'(dout_valid), 16'h0000);
        check("dout_hold", dout, 16'h0044);

        // Reset mid-handshake
        @(posedge clk); #1;
        bus_write(16'hFE06, 16'h0055);
        kb_push(8'h77);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_disp_valid", 16'(disp_valid), 16'h0000);
        check("rst_mid_kb_irq", 16'(kb_irq), 16'h0000);
        check("rst_mid_kb_ready", 16'(kb_ready), 16'h0001);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_read("kbsr_after_rst", 16'hFE00, 16'h0000);
        bus_read("dsr_after_rst", 16'hFE04, 16'h8000);
        bus_read("ddr_after_rst", 16'hFE06, 16'h0000);

        idle(3);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
